// File: rtl/control_unit.sv
// Multi-cycle phase sequencer: walks each instruction through eight datapath
// phases, driving one registered one-hot enable per phase.
module control_unit #(
  parameter int unsigned STAGE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic top_en,
  output logic IF,
  output logic ID,
  output logic REG,
  output logic EX,
  output logic MEM,
  output logic WB,
  output logic BR,
  output logic JU
);

  typedef enum logic [3:0] {
    IDLE, S_IF, S_ID, S_REG, S_EX, S_MEM, S_WB, S_BR, S_JU
  } state_t;

  localparam logic [7:0] LAST = 8'(STAGE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] en_q, en_d;

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_IF:    return S_ID;
      S_ID:    return S_REG;
      S_REG:   return S_EX;
      S_EX:    return S_MEM;
      S_MEM:   return S_WB;
      S_WB:    return S_BR;
      S_BR:    return S_JU;
      default: return S_IF;
    endcase
  endfunction

  function automatic logic [7:0] decode(input state_t s);
    case (s)
      S_IF:    return 8'b0000_0001;
      S_ID:    return 8'b0000_0010;
      S_REG:   return 8'b0000_0100;
      S_EX:    return 8'b0000_1000;
      S_MEM:   return 8'b0001_0000;
      S_WB:    return 8'b0010_0000;
      S_BR:    return 8'b0100_0000;
      S_JU:    return 8'b1000_0000;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Only cycles with the enable actually asserted count toward dwell, so the
  // edge that ends a pause re-asserts the current phase instead of advancing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    if (state_q == IDLE) begin
      if (top_en) begin
        state_d = S_IF;
        cnt_d   = '0;
      end
    end else if (top_en && (en_q != '0)) begin
      if (cnt_q == LAST) begin
        state_d = next_phase(state_q);
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (top_en) en_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign IF  = en_q[0];
  assign ID  = en_q[1];
  assign REG = en_q[2];
  assign EX  = en_q[3];
  assign MEM = en_q[4];
  assign WB  = en_q[5];
  assign BR  = en_q[6];
  assign JU  = en_q[7];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (dwell 1 and 3) share stimulus and are
// checked every cycle against a phase/dwell model, plus literal waveform points.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst, top_en;
  logic [7:0] o1, o3;

  always #5 clk = ~clk;

  control_unit #(.STAGE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .top_en(top_en),
    .IF(o1[0]), .ID(o1[1]), .REG(o1[2]), .EX(o1[3]),
    .MEM(o1[4]), .WB(o1[5]), .BR(o1[6]), .JU(o1[7])
  );

  control_unit #(.STAGE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .top_en(top_en),
    .IF(o3[0]), .ID(o3[1]), .REG(o3[2]), .EX(o3[3]),
    .MEM(o3[4]), .WB(o3[5]), .BR(o3[6]), .JU(o3[7])
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Model: phase index (-1 = idle), count of enabled cycles spent in the
  // phase, and whether the phase enable is currently visible.
  int sc[2] = '{1, 3};
  int ph[2] = '{-1, -1};
  int cnt[2] = '{0, 0};
  bit act[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = -1; cnt[k] = 0; act[k] = 1'b0;
      end else if (ph[k] < 0) begin
        if (top_en) begin ph[k] = 0; cnt[k] = 0; act[k] = 1'b1; end
      end else if (!top_en) begin
        act[k] = 1'b0;
      end else if (act[k]) begin
        cnt[k] = cnt[k] + 1;
        if (cnt[k] == sc[k]) begin
          ph[k] = (ph[k] + 1) % 8;
          cnt[k] = 0;
        end
      end else begin
        act[k] = 1'b1;
      end
    end
  end

  function automatic logic [7:0] model_out(input int p, input bit a);
    logic [7:0] v;
    v = '0;
    if (a && p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (o1 !== model_out(ph[0], act[0])) begin
        miscompares++;
        $display("FAIL model_sc1 t=%0t got=%b exp=%b", $time, o1, model_out(ph[0], act[0]));
      end
      vectors++;
      if (o3 !== model_out(ph[1], act[1])) begin
        miscompares++;
        $display("FAIL model_sc3 t=%0t got=%b exp=%b", $time, o3, model_out(ph[1], act[1]));
      end
      vectors++;
      if (!$onehot0(o1) || !$onehot0(o3)) begin
        miscompares++;
        $display("FAIL onehot t=%0t got1=%b got3=%b exp=onehot0", $time, o1, o3);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; top_en = 1'b0;
    step(3);
    chk_on = 1'b1;
    lit("reset_sc1", o1, 8'h00);
    lit("reset_sc3", o3, 8'h00);
    rst = 1'b0;
    step(5);
    lit("idle_sc1", o1, 8'h00);

    // Continuous run
    top_en = 1'b1;
    step(1);
    lit("start_if_sc1", o1, 8'h01);
    lit("start_if_sc3", o3, 8'h01);
    step(3);
    lit("ex_4th_sc1", o1, 8'h08);
    step(4);
    lit("ju_8th_sc1", o1, 8'h80);
    step(1);
    lit("if_again_9", o1, 8'h01);
    lit("sc3_reg_9", o3, 8'h04);
    step(8);
    lit("if_again_17", o1, 8'h01);
    step(7);
    lit("sc3_ju_24", o3, 8'h80);
    step(1);
    lit("sc3_if_25", o3, 8'h01);

    // Pause while dut1 shows EX
    step(3);
    lit("pre_pause_ex", o1, 8'h08);
    top_en = 1'b0;
    step(1);
    lit("pause1_sc1", o1, 8'h00);
    lit("pause1_sc3", o3, 8'h00);
    step(2);
    lit("pause3_sc1", o1, 8'h00);
    top_en = 1'b1;
    step(1);
    lit("resume_ex", o1, 8'h08);
    step(1);
    lit("resume_mem", o1, 8'h10);

    // Reset mid-instruction with top_en held
    rst = 1'b1;
    step(1);
    lit("midrst_idle", o1, 8'h00);
    rst = 1'b0;
    step(1);
    lit("midrst_if", o1, 8'h01);
    lit("midrst_if_sc3", o3, 8'h01);

    // Reset wins over top_en
    rst = 1'b1;
    step(2);
    lit("prio_idle", o1, 8'h00);
    lit("prio_idle_sc3", o3, 8'h00);
    rst = 1'b0;
    step(1);
    lit("prio_if", o1, 8'h01);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      top_en = ($urandom_range(0, 99) < 75);
      rst    = ($urandom_range(0, 99) < 2);
      step(1);
    end
    rst = 1'b0; top_en = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
